retire_trace_drain: RTL and testbench

RETIRE_TRACE_DRAIN -- requirements
Module: retire_trace_drain

---
 rtl/cod_trace_pkg.sv | 31 +++
 rtl/trace_sync_fifo.sv | 61 ++++++
 rtl/retire_trace_drain.sv | 73 +++++++
 tb/tb_retire_trace_drain.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/cod_trace_pkg.sv
// Shared layout of the 70-bit retire record and the beat encoding used to
// serialize it onto the 32-bit trace port.
package cod_trace_pkg;

  localparam int TRACE_W   = 70;
  localparam int PC_LSB    = 0;
  localparam int WDATA_LSB = 32;
  localparam int WADDR_LSB = 64;
  localparam int WEN_BIT   = 69;
  localparam int BEATS     = 3;

  typedef logic [TRACE_W-1:0] trace_rec_t;

  typedef enum logic [1:0] {
    BEAT_PC    = 2'd0,
    BEAT_WDATA = 2'd1,
    BEAT_REG   = 2'd2
  } beat_e;

  localparam beat_e LAST_BEAT = beat_e'(2'(BEATS - 1));

  function automatic logic [31:0] beat_word(input trace_rec_t rec, input beat_e beat);
    case (beat)
      BEAT_PC:    beat_word = rec[PC_LSB +: 32];
      BEAT_WDATA: beat_word = rec[WDATA_LSB +: 32];
      BEAT_REG:   beat_word = {26'b0, rec[WEN_BIT], rec[WADDR_LSB +: 5]};
      default:    beat_word = 32'b0;
    endcase
  endfunction

endpackage

// File: rtl/trace_sync_fifo.sv
// Synchronous FIFO holding retire records; count is the single source of
// truth for full/empty so pointers may wrap freely modulo DEPTH.
module trace_sync_fifo
  import cod_trace_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  trace_rec_t               i_push_data,
  input  logic                     i_pop,
  output trace_rec_t               o_head_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  trace_rec_t    r_mem [DEPTH];

  logic w_do_push;
  logic w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;

  // NOTE: storage carries no reset; consumers only see it while count != 0.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
  end

  assign o_head_data = r_mem[r_rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/retire_trace_drain.sv
// Buffers retired-instruction records from WB and drains each one as three
// valid/ready beats: pc, wdata, then {wen, waddr} flagged with trace_last.
module retire_trace_drain
  import cod_trace_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     retired,
  input  logic [TRACE_W-1:0]       fifo_data,
  output logic                     fifo_full,
  output logic                     trace_valid,
  input  logic                     trace_ready,
  output logic [31:0]              trace_word,
  output logic                     trace_last,
  output logic [$clog2(DEPTH):0]   occupancy
);

  beat_e      r_beat;
  beat_e      w_beat_next;
  trace_rec_t w_head;
  logic       w_empty;
  logic       w_push;
  logic       w_pop;
  logic       w_xfer;

  assign w_push      = retired & ~fifo_full & ~rst;
  assign trace_valid = ~w_empty;
  assign w_xfer      = trace_valid & trace_ready;
  assign w_pop       = w_xfer & (r_beat == LAST_BEAT);

  trace_sync_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_push_data (fifo_data),
    .i_pop       (w_pop),
    .o_head_data (w_head),
    .o_full      (fifo_full),
    .o_empty     (w_empty),
    .o_count     (occupancy)
  );

  always_ff @(posedge clk) begin
    if (rst) r_beat <= BEAT_PC;
    else     r_beat <= w_beat_next;
  end

  always_comb begin
    w_beat_next = r_beat;
    if (w_xfer) begin
      case (r_beat)
        BEAT_PC:    w_beat_next = BEAT_WDATA;
        BEAT_WDATA: w_beat_next = BEAT_REG;
        default:    w_beat_next = BEAT_PC;
      endcase
    end
  end

  // NOTE: defaults first so no path through this block infers a latch.
  always_comb begin
    trace_word = '0;
    trace_last = 1'b0;
    if (trace_valid) begin
      trace_word = beat_word(w_head, r_beat);
      trace_last = (r_beat == LAST_BEAT);
    end
  end

endmodule

// File: tb/tb_retire_trace_drain.sv
// Directed bench for retire_trace_drain: single record, fill/release, stall,
// randomized-ready streaming with wrap, and mid-operation reset.
module tb_retire_trace_drain;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        retired = 1'b0;
  logic [69:0] fifo_data = '0;
  logic        trace_ready = 1'b0;
  logic        fifo_full;
  logic        trace_valid;
  logic [31:0] trace_word;
  logic        trace_last;
  logic [3:0]  occupancy;

  int checks   = 0;
  int failures = 0;

  logic [32:0] exp_q[$];

  retire_trace_drain #(.DEPTH(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .retired     (retired),
    .fifo_data   (fifo_data),
    .fifo_full   (fifo_full),
    .trace_valid (trace_valid),
    .trace_ready (trace_ready),
    .trace_word  (trace_word),
    .trace_last  (trace_last),
    .occupancy   (occupancy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [69:0] mk_rec(input int i);
    return {i[0], 5'(i + 3), 32'hA5A5_0000 ^ 32'(i), 32'h0000_1000 + 32'(i * 4)};
  endfunction

  task automatic push_exp(input logic [69:0] r);
    exp_q.push_back({1'b0, r[31:0]});
    exp_q.push_back({1'b0, r[63:32]});
    exp_q.push_back({1'b1, 26'b0, r[69], r[68:64]});
  endtask

  task automatic check_beat(input string tag);
    logic [32:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_unexpected_beat"}, 32'(trace_valid), 32'd0);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_word"}, trace_word, e[31:0]);
      check({tag, "_last"}, 32'(trace_last), 32'(e[32]));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int  next;
    int  cyc;
    bit  acc;
    bit  xfer;

    // Reset state
    tick();
    tick();
    check("rst_occ",   32'(occupancy),   32'd0);
    check("rst_valid", 32'(trace_valid), 32'd0);
    check("rst_full",  32'(fifo_full),   32'd0);
    check("rst_last",  32'(trace_last),  32'd0);
    check("rst_word",  trace_word,       32'h0);
    rst = 1'b0;

    // Single record, ready held high
    trace_ready = 1'b1;
    retired     = 1'b1;
    fifo_data   = {1'b1, 5'd3, 32'hDEADBEEF, 32'h1C000000};
    tick();
    retired = 1'b0;
    check("single_b0_valid", 32'(trace_valid), 32'd1);
    check("single_b0_word",  trace_word,       32'h1C000000);
    check("single_b0_last",  32'(trace_last),  32'd0);
    tick();
    check("single_b1_word",  trace_word,       32'hDEADBEEF);
    check("single_b1_last",  32'(trace_last),  32'd0);
    tick();
    check("single_b2_word",  trace_word,       32'h00000023);
    check("single_b2_last",  32'(trace_last),  32'd1);
    tick();
    check("single_idle_valid", 32'(trace_valid), 32'd0);
    check("single_idle_word",  trace_word,       32'h0);

    // Fill with ready low: ninth record is held off
    trace_ready = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 9; i++) begin
      retired   = 1'b1;
      fifo_data = mk_rec(i);
      check("fill_full_pre", 32'(fifo_full), (i == 8) ? 32'd1 : 32'd0);
      tick();
      if (i < 8) push_exp(mk_rec(i));
    end
    check("fill_occ",   32'(occupancy), 32'd8);
    check("fill_full",  32'(fifo_full), 32'd1);
    check("fill_head",  trace_word,     32'h0000_1000);

    // Release from full: pop at beat2, slot reused next cycle
    trace_ready = 1'b1;
    for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
      if (c == 2) check("rel_full_at_beat2", 32'(fifo_full), 32'd1);
      if (c == 3) begin
        check("rel_full_drop", 32'(fifo_full), 32'd0);
        check("rel_occ_7",     32'(occupancy), 32'd7);
      end
      if (c == 4) check("rel_occ_refill", 32'(occupancy), 32'd8);
      acc = retired && !fifo_full;
      if (trace_valid) check_beat("rel");
      else check("rel_valid", 32'(trace_valid), 32'd1);
      tick();
      if (acc) begin
        push_exp(mk_rec(8));
        retired = 1'b0;
      end
    end
    check("rel_remaining", 32'(exp_q.size()), 32'd0);
    check("rel_retired_taken", 32'(retired), 32'd0);
    check("rel_idle_valid", 32'(trace_valid), 32'd0);

    // Stall during beat1 for four cycles
    trace_ready = 1'b0;
    retired     = 1'b1;
    fifo_data   = mk_rec(50);
    tick();
    retired = 1'b0;
    check("stall_b0_word", trace_word, 32'h0000_10C8);
    trace_ready = 1'b1;
    tick();
    check("stall_b1_word", trace_word, 32'hA5A5_0032);
    trace_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("stall_hold_word",  trace_word,       32'hA5A5_0032);
      check("stall_hold_valid", 32'(trace_valid), 32'd1);
      check("stall_hold_last",  32'(trace_last),  32'd0);
    end
    trace_ready = 1'b1;
    tick();
    check("stall_b2_word", trace_word,      32'h0000_0015);
    check("stall_b2_last", 32'(trace_last), 32'd1);
    tick();
    check("stall_idle_valid", 32'(trace_valid), 32'd0);

    // Stream 20 records with ~50% ready; pointers wrap several times
    exp_q.delete();
    next = 0;
    cyc  = 0;
    while ((next < 20 || exp_q.size() > 0) && cyc < 600) begin
      trace_ready = 1'($urandom_range(0, 1));
      retired     = (next < 20);
      fifo_data   = mk_rec(100 + next);
      acc  = retired && !fifo_full;
      xfer = trace_valid && trace_ready;
      if (xfer) check_beat("wrap");
      tick();
      cyc++;
      if (acc) begin
        push_exp(mk_rec(100 + next));
        next++;
      end
    end
    retired = 1'b0;
    check("wrap_pushed",    32'(next),         32'd20);
    check("wrap_remaining", 32'(exp_q.size()), 32'd0);
    check("wrap_occ",       32'(occupancy),    32'd0);

    // Reset mid-record with three records stored
    trace_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      retired   = 1'b1;
      fifo_data = mk_rec(60 + i);
      tick();
    end
    retired = 1'b0;
    check("mrst_occ3", 32'(occupancy), 32'd3);
    trace_ready = 1'b1;
    tick();
    check("mrst_b1_word", trace_word, 32'hA5A5_003C);
    rst       = 1'b1;
    retired   = 1'b1;
    fifo_data = mk_rec(70);
    tick();
    check("mrst_occ",   32'(occupancy),   32'd0);
    check("mrst_valid", 32'(trace_valid), 32'd0);
    check("mrst_full",  32'(fifo_full),   32'd0);
    check("mrst_word",  trace_word,       32'h0);
    check("mrst_last",  32'(trace_last),  32'd0);
    rst = 1'b0;
    tick();
    retired = 1'b0;
    check("mrst_push_occ", 32'(occupancy), 32'd1);
    check("mrst_b0_word",  trace_word,     32'h0000_1118);
    tick();
    check("mrst_b1_word2", trace_word,     32'hA5A5_0046);
    tick();
    check("mrst_b2_word",  trace_word,      32'h0000_0009);
    check("mrst_b2_last",  32'(trace_last), 32'd1);
    tick();
    check("mrst_idle_valid", 32'(trace_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
